// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with occupancy flags and sticky error flags.
// Pointers carry one extra wrap bit so full and empty can be told apart
// without a separate counter; count falls out of the pointer difference.
// fwft_p selects a registered read port (0) or first-word-fall-through (1).
`timescale 1ns/1ps

module sync_fifo_flags #(
    parameter int unsigned data_width_p = 8,
    parameter int unsigned addr_size_p  = 8,
    parameter int unsigned mem_depth_p  = 256,
    parameter bit          fwft_p       = 1'b0,
    parameter int unsigned af_level_p   = 252,
    parameter int unsigned ae_level_p   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [data_width_p-1:0] data_in,
    input  logic                    clr_err,
    output logic [data_width_p-1:0] data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [addr_size_p:0]    count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int unsigned PtrW = addr_size_p + 1;
    localparam logic [addr_size_p:0] AfLevel = PtrW'(af_level_p);
    localparam logic [addr_size_p:0] AeLevel = PtrW'(ae_level_p);

    logic [addr_size_p:0]    wr_ptr_q;
    logic [addr_size_p:0]    rd_ptr_q;
    logic [data_width_p-1:0] mem_q [mem_depth_p];

    logic                    wr_acc;
    logic                    rd_acc;
    logic [addr_size_p-1:0]  wr_addr;
    logic [addr_size_p-1:0]  rd_addr;
    logic [data_width_p-1:0] rd_word;

    // Flag decode and access qualification, all from the registered pointers.
    always_comb begin
        wr_addr      = wr_ptr_q[addr_size_p-1:0];
        rd_addr      = rd_ptr_q[addr_size_p-1:0];
        empty        = (wr_ptr_q == rd_ptr_q);
        full         = (wr_ptr_q[addr_size_p] != rd_ptr_q[addr_size_p]) &&
                       (wr_addr == rd_addr);
        count        = wr_ptr_q - rd_ptr_q;
        almost_full  = (count >= AfLevel);
        almost_empty = (count <= AeLevel);
        wr_acc       = wr_en && !full;
        rd_acc       = rd_en && !empty;
        rd_word      = mem_q[rd_addr];
    end

    // Pointer advance; rejected accesses leave the pointers untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (rd_acc) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    // Sticky error flags: a new error in the same cycle as clr_err wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    if (fwft_p == 1'b0) begin : g_reg_read
        logic [data_width_p-1:0] dout_q;

        // Registered read port: load the head word on the edge that pops it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= rd_word;
            end
        end

        assign data_out = dout_q;
    end else begin : g_fwft_read
        // Head word is visible whenever stored; zero while empty (and so in reset).
        always_comb begin
            data_out = empty ? '0 : rd_word;
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a registered-read and a FWFT instance share stimulus
// and are compared every cycle against a queue-based model of the FIFO.
`timescale 1ns/1ps

module tb_sync_fifo_flags;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 14;
    localparam int unsigned AE    = 2;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] data_in;

    logic [7:0] dout0, dout1;
    logic       full0, full1, empty0, empty1, af0, af1, ae0, ae1;
    logic       ovf0, ovf1, unf0, unf1;
    logic [4:0] count0, count1;

    int tests;
    int fails;

    // Behavioural model: contents as a queue, plus the registered read value.
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_unf;
    logic [7:0] m_dout0;

    sync_fifo_flags #(
        .data_width_p(8), .addr_size_p(4), .mem_depth_p(16),
        .fwft_p(1'b0), .af_level_p(14), .ae_level_p(2)
    ) dut_reg (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
        .clr_err(clr_err), .data_out(dout0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_flags #(
        .data_width_p(8), .addr_size_p(4), .mem_depth_p(16),
        .fwft_p(1'b1), .af_level_p(14), .ae_level_p(2)
    ) dut_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in),
        .clr_err(clr_err), .data_out(dout1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(unf1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_dout0 = 8'h00;
    endtask

    // One clock edge of the FIFO rules, evaluated on the occupancy before the edge.
    task automatic model_step();
        int sz;
        bit mfull;
        bit mempty;
        sz     = mq.size();
        mfull  = (sz == DEPTH);
        mempty = (sz == 0);
        if (wr_en && mfull) m_ovf = 1'b1;
        else if (clr_err)   m_ovf = 1'b0;
        if (rd_en && mempty) m_unf = 1'b1;
        else if (clr_err)    m_unf = 1'b0;
        if (rd_en && !mempty) m_dout0 = mq.pop_front();
        if (wr_en && !mfull) mq.push_back(data_in);
    endtask

    task automatic compare_all();
        int sz;
        sz = mq.size();
        chk("count_reg",  32'(count0), 32'(sz));
        chk("count_fwft", 32'(count1), 32'(sz));
        chk("full_reg",   32'(full0),  32'(sz == DEPTH));
        chk("full_fwft",  32'(full1),  32'(sz == DEPTH));
        chk("empty_reg",  32'(empty0), 32'(sz == 0));
        chk("empty_fwft", 32'(empty1), 32'(sz == 0));
        chk("af_reg",     32'(af0),    32'(sz >= AF));
        chk("af_fwft",    32'(af1),    32'(sz >= AF));
        chk("ae_reg",     32'(ae0),    32'(sz <= AE));
        chk("ae_fwft",    32'(ae1),    32'(sz <= AE));
        chk("ovf_reg",    32'(ovf0),   32'(m_ovf));
        chk("ovf_fwft",   32'(ovf1),   32'(m_ovf));
        chk("unf_reg",    32'(unf0),   32'(m_unf));
        chk("unf_fwft",   32'(unf1),   32'(m_unf));
        chk("dout_reg",   32'(dout0),  32'(m_dout0));
        if (sz > 0) chk("dout_fwft", 32'(dout1), 32'(mq[0]));
    endtask

    // Drive one cycle from a falling edge; check on the next falling edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c);
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        clr_err = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_values();
        chk("rst_count_reg",  32'(count0), 0);
        chk("rst_count_fwft", 32'(count1), 0);
        chk("rst_empty_reg",  32'(empty0), 1);
        chk("rst_empty_fwft", 32'(empty1), 1);
        chk("rst_full_reg",   32'(full0),  0);
        chk("rst_full_fwft",  32'(full1),  0);
        chk("rst_ae_reg",     32'(ae0),    1);
        chk("rst_af_reg",     32'(af0),    0);
        chk("rst_ovf_reg",    32'(ovf0),   0);
        chk("rst_unf_reg",    32'(unf0),   0);
        chk("rst_unf_fwft",   32'(unf1),   0);
        chk("rst_dout_reg",   32'(dout0),  0);
        chk("rst_dout_fwft",  32'(dout1),  0);
    endtask

    initial begin
        int pw;
        int pr;
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        data_in = 8'h00;
        model_reset();
        #2;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 8'h00, 1'b0);

        // Fill with 0x01..0x10, then one write too many.
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i), 1'b0);
            chk("fill_count", 32'(count0), i);
            chk("fill_almost_full", 32'(af0), (i >= 14) ? 1 : 0);
        end
        chk("full_after_16", 32'(full0), 1);
        cyc(1'b1, 1'b0, 8'h77, 1'b0);
        chk("overflow_17th", 32'(ovf0), 1);
        chk("count_17th", 32'(count0), 16);

        // Clear collides with a fresh overflow: the set wins; clear alone then works.
        cyc(1'b1, 1'b0, 8'h55, 1'b1);
        chk("overflow_set_beats_clr", 32'(ovf0), 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("overflow_cleared", 32'(ovf0), 0);

        // Drain in order; FWFT shows the head before the pop.
        for (int i = 1; i <= 16; i++) begin
            chk("fwft_head", 32'(dout1), i);
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
            chk("drain_data", 32'(dout0), i);
        end
        chk("empty_after_drain", 32'(empty0), 1);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("underflow_set", 32'(unf0), 1);
        chk("dout_held_on_reject", 32'(dout0), 16);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("underflow_cleared", 32'(unf0), 0);

        // FWFT word appears without a read.
        cyc(1'b1, 1'b0, 8'hA5, 1'b0);
        chk("fwft_a5", 32'(dout1), 32'h0000_00A5);
        chk("not_empty_after_write", 32'(empty0), 0);
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        chk("reg_a5", 32'(dout0), 32'h0000_00A5);

        // Write and read together on empty: only the write goes in.
        cyc(1'b1, 1'b1, 8'h3C, 1'b0);
        chk("empty_wr_rd_count", 32'(count0), 1);
        chk("empty_wr_rd_underflow", 32'(unf0), 1);
        cyc(1'b0, 1'b1, 8'h00, 1'b1);
        chk("empty_wr_rd_data", 32'(dout0), 32'h0000_003C);
        chk("empty_wr_rd_unf_clr", 32'(unf0), 0);

        // Steady streaming at half occupancy; pointers lap the memory twice.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'(8'h20 + i), 1'b0);
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 1'b1, 8'(8'h40 + k), 1'b0);
            chk("stream_count", 32'(count0), 8);
            chk("stream_order", 32'(dout0), (k < 8) ? (32'h20 + k) : (32'h40 + k - 8));
        end
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 8'h00, 1'b0);
            chk("stream_tail", 32'(dout0), 32'h60 + i);
        end

        // Write and read together while full: only the read goes in.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'($urandom), 1'b0);
        cyc(1'b1, 1'b1, 8'hEE, 1'b0);
        chk("full_wr_rd_count", 32'(count0), 15);
        chk("full_wr_rd_overflow", 32'(ovf0), 1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 15; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);

        // Asynchronous reset mid-burst at count 9 with underflow pending.
        cyc(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
        chk("pre_reset_count", 32'(count0), 9);
        chk("pre_reset_unf", 32'(unf0), 1);
        #1;
        rst = 1'b1;
        model_reset();
        #2;
        check_reset_values();
        #1;
        rst = 1'b0;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        chk("post_reset_count", 32'(count0), 1);

        // Randomised traffic with shifting bias to visit both full and empty.
        for (int seg = 0; seg < 8; seg++) begin
            pw = (seg % 2 == 0) ? 80 : 20;
            pr = (seg % 2 == 0) ? 30 : 85;
            if (seg >= 6) begin
                pw = 55;
                pr = 55;
            end
            for (int n = 0; n < 250; n++) begin
                cyc(($urandom_range(0, 99) < pw) ? 1'b1 : 1'b0,
                    ($urandom_range(0, 99) < pr) ? 1'b1 : 1'b0,
                    8'($urandom),
                    ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
